// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr
// -----------------------------------------------------------------------------
// N-channel to 1 multiplexer with a single registered output stage and a
// valid/ready handshake on every port. The source channel comes either from a
// fixed select input (mode = 0) or from a round-robin arbiter (mode = 1).
// Multi-beat packets stay locked to their channel until the last beat.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed-select mode
//   in_valid   per-channel beat valid
//   in_data    per-channel data, channel i at [i*WIDTH +: WIDTH]
//   in_last    per-channel last-beat-of-packet flag
//   in_ready   per-channel accept (at most one-hot, depends on out_ready)
//   out_valid  output register holds a beat
//   out_data   registered data
//   out_ch     source channel of out_data
//   out_last   registered last flag
//   out_ready  consumer accepts the output beat
// -----------------------------------------------------------------------------
module mux_nto1_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_last,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_ch,
  output logic                   out_last,
  input  logic                   out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  state_t            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;

  logic [WIDTH-1:0]  ch_data [NCH];
  logic [SELW-1:0]   rr_idx;
  logic              rr_hit;
  logic [SELW-1:0]   grant_idx;
  logic              grant_any;
  logic              grant_last;
  logic              sel_ok;
  logic              load;

  // Unpack the flat data bus so the granted channel can be picked by index.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: walk downward so the lowest offset from ptr wins.
  always_comb begin
    int j;
    rr_idx = '0;
    rr_hit = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      if (in_valid[j]) begin
        rr_hit = 1'b1;
        rr_idx = SELW'(j);
      end
    end
  end

  // An out-of-range select (possible when NCH is not a power of two) never grants.
  assign sel_ok = ({1'b0, sel} < NCH_W);

  // Grant selection: a lock overrides mode and sel entirely.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    if (state_q == LOCKED) begin
      grant_idx = lock_ch_q;
      grant_any = in_valid[lock_ch_q];
    end else if (!mode) begin
      if (sel_ok) begin
        grant_idx = sel;
        grant_any = in_valid[sel];
      end
    end else begin
      grant_idx = rr_idx;
      grant_any = rr_hit;
    end
  end

  assign grant_last = in_last[grant_idx];

  // The output register can take a new beat when empty or draining this cycle.
  assign load = (!out_valid_q | out_ready) & grant_any;

  // rst_n gating keeps every in_ready low while reset is held.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n & load & (grant_idx == SELW'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      out_last_d  = grant_last;

      case (state_q)
        IDLE: begin
          if (!grant_last) begin
            state_d   = LOCKED;
            lock_ch_d = grant_idx;
          end
        end
        LOCKED: begin
          if (grant_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // The pointer only advances at packet boundaries so a packet is never split.
      if (mode && grant_last) begin
        ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_ready) begin
      // Drained with nothing to replace it; payload registers keep their value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Testbench for mux_nto1_rr (NCH = 4, WIDTH = 8).
// A reference model predicts each accepted beat and pushes it to a queue; a
// separate monitor compares the output register against the queue head.
module tb_mux_nto1_rr;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 mode = 1'b1;
  logic [SELW-1:0]      sel = '0;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH*WIDTH-1:0] in_data = '0;
  logic [NCH-1:0]       in_last = '0;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_last;
  logic                 out_ready = 1'b1;

  mux_nto1_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
    logic             last;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    hist_q[$];

  // Reference model state
  bit m_locked = 1'b0;
  int m_lock   = 0;
  int m_ptr    = 0;
  bit m_ov     = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: evaluated at negedge on the inputs for the next posedge.
  always @(negedge clk) begin
    int  g;
    bit  ld;
    int  c;
    logic [NCH-1:0] exp_rdy;
    beat_t b;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      m_locked = 1'b0;
      m_lock   = 0;
      m_ptr    = 0;
      m_ov     = 1'b0;
      exp_q.delete();
    end else begin
      check("out_valid", out_valid, m_ov);
      g = -1;
      if (m_locked) begin
        if (in_valid[m_lock]) g = m_lock;
      end else if (!mode) begin
        if (int'(sel) < NCH && in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (g < 0 && in_valid[c]) g = c;
        end
      end
      ld = (g >= 0) && (!m_ov || out_ready);
      exp_rdy = '0;
      if (ld) exp_rdy[g] = 1'b1;
      check("in_ready", in_ready, exp_rdy);
      if (ld) begin
        b.data = in_data[g*WIDTH +: WIDTH];
        b.ch   = SELW'(g);
        b.last = in_last[g];
        exp_q.push_back(b);
        if (!m_locked && !in_last[g]) begin
          m_locked = 1'b1;
          m_lock   = g;
        end else if (m_locked && in_last[g]) begin
          m_locked = 1'b0;
        end
        if (mode && in_last[g]) m_ptr = (g + 1) % NCH;
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Monitor: the presented beat must match the oldest predicted beat.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        check("out_data", out_data, exp_q[0].data);
        check("out_ch", out_ch, exp_q[0].ch);
        check("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          hist_q.push_back(int'(out_ch));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus: inputs apply to the next rising edge.
  task automatic cyc(input logic [NCH-1:0] v, input logic [NCH-1:0] l,
                     input logic r, input logic m, input logic [SELW-1:0] s);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    mode      = m;
    sel       = s;
    in_data   = $urandom;
  endtask

  initial begin
    int rr_exp[6];
    int lk_exp[4];
    logic [NCH-1:0] rv;
    logic [NCH-1:0] rl;
    logic rm;

    rr_exp = '{0, 1, 2, 3, 0, 1};
    lk_exp = '{1, 1, 1, 2};

    // Reset with every channel requesting
    rst_n = 1'b0;
    in_valid = '1;
    in_last = '1;
    mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("first_grant", in_ready, 4'b0001);
    hist_q.delete();

    // Round-robin fairness, single-beat packets
    repeat (5) cyc(4'hF, 4'hF, 1'b1, 1'b1, 2'd0);
    repeat (2) cyc(4'h0, 4'h0, 1'b1, 1'b1, 2'd0);
    check("rr_count", hist_q.size(), 6);
    for (int i = 0; i < 6 && i < hist_q.size(); i++) check("rr_order", hist_q[i], rr_exp[i]);

    // Fixed select
    hist_q.delete();
    repeat (3) begin
      cyc(4'hF, 4'hF, 1'b1, 1'b0, 2'd2);
      in_data[2*WIDTH +: WIDTH] = 8'hA5;
      #1;
      check("fixsel_in_ready", in_ready, 4'b0100);
    end
    repeat (2) cyc(4'h0, 4'h0, 1'b1, 1'b0, 2'd2);
    check("fixsel_count", hist_q.size(), 3);
    check("fixsel_hold_data", out_data, 8'hA5);
    check("fixsel_hold_ch", out_ch, 2);

    // Packet lock on ch1 with a two-cycle gap mid-packet
    hist_q.delete();
    cyc(4'b0010, 4'b0000, 1'b1, 1'b1, 2'd0);
    cyc(4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0);
    repeat (2) begin
      cyc(4'b1101, 4'b1111, 1'b1, 1'b1, 2'd0);
      #1;
      check("lock_gap_in_ready", in_ready, 4'b0000);
    end
    cyc(4'b1111, 4'b0010, 1'b1, 1'b1, 2'd0);
    cyc(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0);
    repeat (2) cyc(4'h0, 4'h0, 1'b1, 1'b1, 2'd0);
    check("lock_count", hist_q.size(), 4);
    for (int i = 0; i < 4 && i < hist_q.size(); i++) check("lock_order", hist_q[i], lk_exp[i]);

    // Backpressure: hold the output for five cycles
    hist_q.delete();
    cyc(4'hF, 4'hF, 1'b1, 1'b1, 2'd0);
    repeat (5) begin
      cyc(4'hF, 4'hF, 1'b0, 1'b1, 2'd0);
      #1;
      check("bp_in_ready", in_ready, 4'b0000);
    end
    repeat (3) cyc(4'hF, 4'hF, 1'b1, 1'b1, 2'd0);
    repeat (2) cyc(4'h0, 4'h0, 1'b1, 1'b1, 2'd0);
    check("bp_count", hist_q.size(), 4);

    // Reset in the middle of a locked ch3 packet
    cyc(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd0);
    cyc(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 4'hF;
    in_last = 4'hF;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mode = 1'b1;
    hist_q.delete();
    #1;
    check("postrst_grant", in_ready, 4'b0001);
    repeat (2) cyc(4'h0, 4'h0, 1'b1, 1'b1, 2'd0);
    check("postrst_count", hist_q.size(), 1);
    if (hist_q.size() > 0) check("postrst_first_ch", hist_q[0], 0);

    // Randomised traffic
    rm = 1'b1;
    repeat (400) begin
      rv = NCH'($urandom);
      rl = NCH'($urandom) | NCH'($urandom);
      if ($urandom_range(0, 19) == 0) rm = ~rm;
      cyc(rv, rl, ($urandom_range(0, 3) != 0), rm, SELW'($urandom));
    end
    repeat (3) cyc(4'h0, 4'h0, 1'b1, rm, 2'd0);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
